// File: rtl/spoly_reader_if.sv
// spoly_reader_if: start/done handshake, coefficient-memory read port and
// coefficient stream for spoly_reader. weight_err exists only when
// SPOLY_WEIGHT_CHECK_EN is defined.
interface spoly_reader_if;
  logic       start;
  logic       write_done;
  logic       mem_rd_en;
  logic [9:0] mem_addr;
  logic [12:0] mem_output;
  logic [1:0] coef_out;
  logic       coef_valid;
  logic       coef_ready;
  logic [9:0] coef_idx;
  logic       busy;
  logic       done;
  logic       fmt_err;
  logic [9:0] weight;
`ifdef SPOLY_WEIGHT_CHECK_EN
  logic       weight_err;

  modport slave (
    input  start, write_done, mem_output, coef_ready,
    output mem_rd_en, mem_addr, coef_out, coef_valid, coef_idx, busy, done, fmt_err, weight,
    output weight_err
  );

  modport master (
    output start, write_done, mem_output, coef_ready,
    input  mem_rd_en, mem_addr, coef_out, coef_valid, coef_idx, busy, done, fmt_err, weight,
    input  weight_err
  );
`else
  modport slave (
    input  start, write_done, mem_output, coef_ready,
    output mem_rd_en, mem_addr, coef_out, coef_valid, coef_idx, busy, done, fmt_err, weight
  );

  modport master (
    output start, write_done, mem_output, coef_ready,
    input  mem_rd_en, mem_addr, coef_out, coef_valid, coef_idx, busy, done, fmt_err, weight
  );
`endif
endinterface

// File: rtl/spoly_reader.sv
// spoly_reader: reads P coefficient words from a synchronous memory, decodes
// each into {0, +1, -1}, streams them with a valid/ready handshake and counts
// the Hamming weight. Optional macro SPOLY_WEIGHT_CHECK_EN adds a weight_err
// flag comparing the final weight against W.
module spoly_reader #(
  parameter int unsigned P = 677,
  parameter int unsigned W = 286
) (
  input logic           clk,
  input logic           rst,
  spoly_reader_if.slave bus_io
);

  typedef enum logic [2:0] {StIdle, StWaitWr, StRd, StLat, StOut, StFin} state_e;

  localparam logic [9:0] LastIdx   = 10'(P - 1);
  localparam logic [9:0] WeightMax = 10'h3FF;

  // Elaboration-time sanity checks on the configuration.
  if (P < 1 || P > 1024) begin : g_bad_p
    $error("spoly_reader: P must be in 1..1024");
  end
  if (W > P) begin : g_bad_w
    $error("spoly_reader: W must not exceed P");
  end

  state_e     state_q, state_d;
  logic [9:0] idx_q, idx_d;
  logic [1:0] coef_q, coef_d;
  logic       fmt_err_q, fmt_err_d;
  logic [9:0] weight_q, weight_d;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic; start is only looked at in IDLE and FIN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus_io.start) state_d = StWaitWr;
      StWaitWr: if (bus_io.write_done) state_d = StRd;
      StRd:     state_d = StLat;
      StLat:    state_d = StOut;
      StOut:    if (bus_io.coef_ready) state_d = (idx_q == LastIdx) ? StFin : StRd;
      StFin:    if (!bus_io.start) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath next-state: index, decoded coefficient, sticky format error, weight.
  always_comb begin
    idx_d     = idx_q;
    coef_d    = coef_q;
    fmt_err_d = fmt_err_q;
    weight_d  = weight_q;
    if (state_q == StIdle && bus_io.start) begin
      idx_d     = '0;
      coef_d    = '0;
      fmt_err_d = 1'b0;
      weight_d  = '0;
    end
    if (state_q == StLat) begin
      case (bus_io.mem_output)
        13'h0000: coef_d = 2'b00;
        13'h0001: coef_d = 2'b01;
        13'h1FFF: coef_d = 2'b11;
        default: begin
          coef_d    = 2'b00;
          fmt_err_d = 1'b1;
        end
      endcase
    end
    if (state_q == StOut && bus_io.coef_ready) begin
      if (coef_q != 2'b00 && weight_q != WeightMax) weight_d = weight_q + 10'd1;
      // Index parks at P-1 in FIN; the next start clears it.
      if (idx_q != LastIdx) idx_d = idx_q + 10'd1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= '0;
      coef_q    <= '0;
      fmt_err_q <= 1'b0;
      weight_q  <= '0;
    end else begin
      idx_q     <= idx_d;
      coef_q    <= coef_d;
      fmt_err_q <= fmt_err_d;
      weight_q  <= weight_d;
    end
  end

`ifdef SPOLY_WEIGHT_CHECK_EN
  localparam logic [9:0] WeightTarget = 10'(W);

  logic weight_err_q, weight_err_d;

  // Weight check: evaluated on the final accept using the updated weight.
  always_comb begin
    weight_err_d = weight_err_q;
    if (state_q == StIdle && bus_io.start) weight_err_d = 1'b0;
    if (state_q == StOut && bus_io.coef_ready && idx_q == LastIdx) begin
      weight_err_d = (weight_d != WeightTarget);
    end
  end

  // Weight-error register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) weight_err_q <= 1'b0;
    else     weight_err_q <= weight_err_d;
  end
`endif

  // Moore outputs.
  always_comb begin
    bus_io.mem_rd_en  = (state_q == StRd);
    bus_io.mem_addr   = idx_q;
    bus_io.coef_out   = coef_q;
    bus_io.coef_valid = (state_q == StOut);
    bus_io.coef_idx   = idx_q;
    bus_io.busy       = (state_q != StIdle);
    bus_io.done       = (state_q == StFin);
    bus_io.fmt_err    = fmt_err_q;
    bus_io.weight     = weight_q;
`ifdef SPOLY_WEIGHT_CHECK_EN
    bus_io.weight_err = weight_err_q;
`endif
  end

endmodule
